// File: rtl/cc_line_fill_engine_if.sv
`default_nettype none
// ============================================================================
//  Module   : cc_line_fill_engine_if
//  Purpose  : Bundles the AXI R channel, miss-address FIFO port and tag/data
//             SRAM write port of the line-fill engine.
//  Modports : master - the fill engine (drives rready, FIFO pop, SRAM write)
//             slave  - the surroundings (memory, FIFO, SRAM)
//  Ports    : mem_r*        AXI R beat data/resp/last/valid, rready back
//             miss_addr_*   show-ahead FIFO head, empty flag, pop strobe
//             w*            SRAM write request/accept, index, {valid,tag}, line
//             crit_*        critical-word forward pulse and data
//             fill_err_o    error pulse on completion, busy_o engine busy
//  Revision : 1.0  initial release
// ============================================================================
interface cc_line_fill_engine_if #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int LINE_BYTES = 64,
  parameter int INDEX_W    = 9
);
  localparam int TAG_W  = ADDR_W - INDEX_W - $clog2(LINE_BYTES);
  localparam int LINE_W = LINE_BYTES * 8;

  logic [DATA_W-1:0]  mem_rdata_i;
  logic [1:0]         mem_rresp_i;
  logic               mem_rlast_i;
  logic               mem_rvalid_i;
  logic               mem_rready_o;
  logic               miss_addr_fifo_empty_i;
  logic [ADDR_W-1:0]  miss_addr_fifo_rdata_i;
  logic               miss_addr_fifo_rden_o;
  logic               wren_o;
  logic               wready_i;
  logic [INDEX_W-1:0] waddr_o;
  logic [TAG_W:0]     wdata_tag_o;
  logic [LINE_W-1:0]  wdata_data_o;
  logic               crit_valid_o;
  logic [DATA_W-1:0]  crit_data_o;
  logic               fill_err_o;
  logic               busy_o;

  modport master (
    input  mem_rdata_i, mem_rresp_i, mem_rlast_i, mem_rvalid_i,
    input  miss_addr_fifo_empty_i, miss_addr_fifo_rdata_i, wready_i,
    output mem_rready_o, miss_addr_fifo_rden_o, wren_o, waddr_o,
    output wdata_tag_o, wdata_data_o, crit_valid_o, crit_data_o,
    output fill_err_o, busy_o
  );

  modport slave (
    output mem_rdata_i, mem_rresp_i, mem_rlast_i, mem_rvalid_i,
    output miss_addr_fifo_empty_i, miss_addr_fifo_rdata_i, wready_i,
    input  mem_rready_o, miss_addr_fifo_rden_o, wren_o, waddr_o,
    input  wdata_tag_o, wdata_data_o, crit_valid_o, crit_data_o,
    input  fill_err_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/cc_line_fill_engine.sv
`default_nettype none
// ============================================================================
//  Module   : cc_line_fill_engine
//  Purpose  : Pops one miss address, collects one AXI R burst placing beats
//             critical-word-first (wrapping) into a line buffer, then writes
//             the line and {valid,tag} into the tag/data SRAM. Errored or
//             malformed bursts are written with valid=0.
//  Ports    : clk  - clock
//             rst  - synchronous active-high reset
//             bus  - cc_line_fill_engine_if.master (R channel, miss FIFO,
//                    SRAM write port, critical word, status)
//  Revision : 1.0  initial release
// ============================================================================
module cc_line_fill_engine #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int LINE_BYTES = 64,
  parameter int INDEX_W    = 9
) (
  input  wire logic              clk,
  input  wire logic              rst,
  cc_line_fill_engine_if.master  bus
);

  localparam int BEATS    = LINE_BYTES * 8 / DATA_W;
  localparam int BEAT_W   = $clog2(BEATS);
  localparam int OFF_LSB  = $clog2(DATA_W / 8);
  localparam int LINE_LSB = $clog2(LINE_BYTES);
  localparam int TAG_W    = ADDR_W - INDEX_W - LINE_LSB;
  localparam int LINE_W   = LINE_BYTES * 8;

  localparam logic [BEAT_W-1:0] C_LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [BEAT_W-1:0] C_ONE       = BEAT_W'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [BEAT_W-1:0]  cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [INDEX_W-1:0] index_q, index_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [BEAT_W-1:0]  off_q, off_d;
  logic [LINE_W-1:0]  line_q, line_d;
  logic [DATA_W-1:0]  crit_data_q, crit_data_d;
  logic               crit_valid_q, crit_valid_d;

  logic               pop;
  logic               is_write;
  logic               last_slot;
  logic [BEAT_W-1:0]  slot;

  // Pop is suppressed while rst is held so a reset cycle never consumes an entry.
  assign pop       = (state_q == ST_IDLE) && !bus.miss_addr_fifo_empty_i && !rst;
  assign is_write  = (state_q == ST_WRITE);
  assign last_slot = (cnt_q == C_LAST_BEAT);
  // Wrap comes for free from the BEAT_W-bit add.
  assign slot      = off_q + cnt_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    index_d      = index_q;
    tag_d        = tag_q;
    off_d        = off_q;
    line_d       = line_q;
    crit_data_d  = crit_data_q;
    crit_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          index_d = bus.miss_addr_fifo_rdata_i[LINE_LSB +: INDEX_W];
          tag_d   = bus.miss_addr_fifo_rdata_i[ADDR_W-1 -: TAG_W];
          off_d   = bus.miss_addr_fifo_rdata_i[OFF_LSB +: BEAT_W];
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (bus.mem_rvalid_i) begin
          for (int k = 0; k < BEATS; k++) begin
            if (slot == BEAT_W'(k)) begin
              line_d[k*DATA_W +: DATA_W] = bus.mem_rdata_i;
            end
          end
          cnt_d = cnt_q + C_ONE;
          if (cnt_q == '0) begin
            crit_data_d  = bus.mem_rdata_i;
            crit_valid_d = 1'b1;
          end
          // Error on bad response, early rlast, or missing rlast on the final beat.
          if ((bus.mem_rresp_i != 2'b00) || (bus.mem_rlast_i != last_slot)) begin
            err_d = 1'b1;
          end
          if (bus.mem_rlast_i || last_slot) begin
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (bus.wready_i) begin
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      index_q      <= '0;
      tag_q        <= '0;
      off_q        <= '0;
      crit_data_q  <= '0;
      crit_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      index_q      <= index_d;
      tag_q        <= tag_d;
      off_q        <= off_d;
      crit_data_q  <= crit_data_d;
      crit_valid_q <= crit_valid_d;
    end
  end

  // Line buffer is deliberately not reset; stale slots are covered by valid=0.
  always_ff @(posedge clk) begin
    line_q <= line_d;
  end

  assign bus.mem_rready_o          = (state_q == ST_FILL);
  assign bus.miss_addr_fifo_rden_o = pop;
  assign bus.wren_o                = is_write;
  // Write payload is gated so every output reads 0 outside WRITE.
  assign bus.waddr_o               = is_write ? index_q : '0;
  assign bus.wdata_tag_o           = is_write ? {~err_q, tag_q} : '0;
  assign bus.wdata_data_o          = is_write ? line_q : '0;
  assign bus.crit_valid_o          = crit_valid_q;
  assign bus.crit_data_o           = crit_data_q;
  assign bus.fill_err_o            = is_write && bus.wready_i && err_q;
  assign bus.busy_o                = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cc_line_fill_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cc_line_fill_engine
//  Purpose  : Directed self-checking bench for cc_line_fill_engine, default
//             build plus a DATA_W=128 / LINE_BYTES=32 build.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cc_line_fill_engine;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   crit_cnt;

  logic [511:0] exp_line;

  cc_line_fill_engine_if #(.ADDR_W(32), .DATA_W(64), .LINE_BYTES(64), .INDEX_W(9)) bus ();
  cc_line_fill_engine_if #(.ADDR_W(32), .DATA_W(128), .LINE_BYTES(32), .INDEX_W(9)) bus2 ();

  cc_line_fill_engine #(.ADDR_W(32), .DATA_W(64), .LINE_BYTES(64), .INDEX_W(9)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  cc_line_fill_engine #(.ADDR_W(32), .DATA_W(128), .LINE_BYTES(32), .INDEX_W(9)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] dv(input int set, input int i);
    return {16'hDA00 + 16'(set), 16'h5A5A, 16'h0000, 16'(i)};
  endfunction

  // Drives n beats of data set 'set'; rresp=2'b10 on err_beat, rlast on last_beat.
  task automatic run_beats(input int set, input int n, input int err_beat, input int last_beat);
    crit_cnt = 0;
    for (int i = 0; i < n; i++) begin
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = dv(set, i);
      bus.mem_rresp_i  = (i == err_beat) ? 2'b10 : 2'b00;
      bus.mem_rlast_i  = (i == last_beat);
      tick();
      if (bus.crit_valid_o) crit_cnt++;
    end
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rlast_i  = 1'b0;
    bus.mem_rresp_i  = 2'b00;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, ".rready"}, 512'(bus.mem_rready_o), 512'd0);
    check({tag, ".rden"},   512'(bus.miss_addr_fifo_rden_o), 512'd0);
    check({tag, ".wren"},   512'(bus.wren_o), 512'd0);
    check({tag, ".waddr"},  512'(bus.waddr_o), 512'd0);
    check({tag, ".tag"},    512'(bus.wdata_tag_o), 512'd0);
    check({tag, ".data"},   512'(bus.wdata_data_o), 512'd0);
    check({tag, ".critv"},  512'(bus.crit_valid_o), 512'd0);
    check({tag, ".critd"},  512'(bus.crit_data_o), 512'd0);
    check({tag, ".ferr"},   512'(bus.fill_err_o), 512'd0);
    check({tag, ".busy"},   512'(bus.busy_o), 512'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.mem_rdata_i = '0;  bus.mem_rresp_i = '0;  bus.mem_rlast_i = 1'b0;
    bus.mem_rvalid_i = 1'b0;  bus.miss_addr_fifo_empty_i = 1'b1;
    bus.miss_addr_fifo_rdata_i = '0;  bus.wready_i = 1'b0;
    bus2.mem_rdata_i = '0;  bus2.mem_rresp_i = '0;  bus2.mem_rlast_i = 1'b0;
    bus2.mem_rvalid_i = 1'b0;  bus2.miss_addr_fifo_empty_i = 1'b1;
    bus2.miss_addr_fifo_rdata_i = '0;  bus2.wready_i = 1'b0;
    tick();
    tick();
    check_zero_outputs("reset");
    rst = 1'b0;
    tick();

    // ---- 1: offset 0, index 1, tag 1, clean burst ----
    bus.miss_addr_fifo_rdata_i = 32'h0000_8040;
    bus.miss_addr_fifo_empty_i = 1'b0;
    #1;
    check("t1.rden_idle", 512'(bus.miss_addr_fifo_rden_o), 512'd1);
    check("t1.rready_idle", 512'(bus.mem_rready_o), 512'd0);
    tick();
    bus.miss_addr_fifo_empty_i = 1'b1;
    check("t1.busy", 512'(bus.busy_o), 512'd1);
    check("t1.rready_fill", 512'(bus.mem_rready_o), 512'd1);
    run_beats(1, 8, -1, 7);
    for (int k = 0; k < 8; k++) exp_line[k*64 +: 64] = dv(1, k);
    check("t1.wren", 512'(bus.wren_o), 512'd1);
    check("t1.waddr", 512'(bus.waddr_o), 512'd1);
    check("t1.tag", 512'(bus.wdata_tag_o), 512'({1'b1, 17'h1}));
    check("t1.data", 512'(bus.wdata_data_o), exp_line);
    check("t1.crit_data", 512'(bus.crit_data_o), 512'(dv(1, 0)));
    bus.wready_i = 1'b1;
    #1;
    check("t1.ferr", 512'(bus.fill_err_o), 512'd0);
    tick();
    bus.wready_i = 1'b0;
    check("t1.wren_done", 512'(bus.wren_o), 512'd0);
    check("t1.busy_done", 512'(bus.busy_o), 512'd0);

    // ---- 2: offset 5, index 0x10, tag 2, wrapped placement ----
    bus.miss_addr_fifo_rdata_i = 32'h0001_0428;
    bus.miss_addr_fifo_empty_i = 1'b0;
    tick();
    bus.miss_addr_fifo_empty_i = 1'b1;
    run_beats(2, 8, -1, 7);
    // slot5=D0, slot6=D1, slot7=D2, slot0=D3 ... slot4=D7
    for (int k = 0; k < 8; k++) exp_line[k*64 +: 64] = dv(2, (k + 3) % 8);
    check("t2.crit_pulses", 512'(crit_cnt), 512'd1);
    check("t2.crit_data", 512'(bus.crit_data_o), 512'(dv(2, 0)));
    check("t2.waddr", 512'(bus.waddr_o), 512'h10);
    check("t2.tag", 512'(bus.wdata_tag_o), 512'({1'b1, 17'h2}));
    check("t2.data", 512'(bus.wdata_data_o), exp_line);
    bus.wready_i = 1'b1;
    tick();
    bus.wready_i = 1'b0;

    // ---- 3: rresp error on beat 3, index 3, tag 4 ----
    bus.miss_addr_fifo_rdata_i = 32'h0002_00C0;
    bus.miss_addr_fifo_empty_i = 1'b0;
    tick();
    bus.miss_addr_fifo_empty_i = 1'b1;
    run_beats(3, 8, 3, 7);
    check("t3.wren", 512'(bus.wren_o), 512'd1);
    check("t3.waddr", 512'(bus.waddr_o), 512'd3);
    check("t3.tag_invalid", 512'(bus.wdata_tag_o), 512'({1'b0, 17'h4}));
    check("t3.ferr_wait", 512'(bus.fill_err_o), 512'd0);
    tick();
    check("t3.wren_held", 512'(bus.wren_o), 512'd1);
    bus.wready_i = 1'b1;
    #1;
    check("t3.ferr", 512'(bus.fill_err_o), 512'd1);
    tick();
    bus.wready_i = 1'b0;
    check("t3.ferr_after", 512'(bus.fill_err_o), 512'd0);
    check("t3.busy_after", 512'(bus.busy_o), 512'd0);

    // ---- 4: early rlast on beat 4 of 8 (A), then B fills normally ----
    bus.miss_addr_fifo_rdata_i = 32'h0000_0100;
    bus.miss_addr_fifo_empty_i = 1'b0;
    tick();
    bus.miss_addr_fifo_rdata_i = 32'h0000_81C0;
    #1;
    check("t4.no_pop_fill", 512'(bus.miss_addr_fifo_rden_o), 512'd0);
    run_beats(4, 4, -1, 3);
    check("t4.wren", 512'(bus.wren_o), 512'd1);
    check("t4.waddr", 512'(bus.waddr_o), 512'd4);
    check("t4.tag_invalid", 512'(bus.wdata_tag_o), 512'({1'b0, 17'h0}));
    check("t4.no_pop_write", 512'(bus.miss_addr_fifo_rden_o), 512'd0);
    bus.wready_i = 1'b1;
    #1;
    check("t4.ferr", 512'(bus.fill_err_o), 512'd1);
    tick();
    bus.wready_i = 1'b0;
    check("t4.rden_next", 512'(bus.miss_addr_fifo_rden_o), 512'd1);
    tick();
    bus.miss_addr_fifo_empty_i = 1'b1;
    run_beats(5, 8, -1, 7);

    // ---- 5: B held in WRITE with wready low, FIFO holds C and D, rvalid high ----
    bus.miss_addr_fifo_rdata_i = 32'h0000_0048;
    bus.miss_addr_fifo_empty_i = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 64'hBAD0_BAD0_BAD0_BAD0;
    for (int k = 0; k < 8; k++) exp_line[k*64 +: 64] = dv(5, k);
    for (int c = 0; c < 5; c++) begin
      #1;
      check("t5.wren_held", 512'(bus.wren_o), 512'd1);
      check("t5.rready_low", 512'(bus.mem_rready_o), 512'd0);
      check("t5.no_pop", 512'(bus.miss_addr_fifo_rden_o), 512'd0);
      check("t5.waddr", 512'(bus.waddr_o), 512'd7);
      check("t5.tag", 512'(bus.wdata_tag_o), 512'({1'b1, 17'h1}));
      check("t5.data", 512'(bus.wdata_data_o), exp_line);
      tick();
    end
    bus.wready_i = 1'b1;
    #1;
    check("t5.ferr", 512'(bus.fill_err_o), 512'd0);
    tick();
    bus.wready_i = 1'b0;
    check("t5.idle_rready", 512'(bus.mem_rready_o), 512'd0);
    check("t5.idle_pop", 512'(bus.miss_addr_fifo_rden_o), 512'd1);
    tick();
    bus.miss_addr_fifo_rdata_i = 32'h0000_40D8;

    // ---- 6: reset at beat 4 of C, then D (offset 3, index 0x103) ----
    run_beats(6, 4, -1, -1);
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = dv(6, 4);
    rst = 1'b1;
    tick();
    check_zero_outputs("t6.rst");
    rst = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    #1;
    check("t6.rden_after", 512'(bus.miss_addr_fifo_rden_o), 512'd1);
    tick();
    bus.miss_addr_fifo_empty_i = 1'b1;
    run_beats(7, 8, -1, 7);
    for (int k = 0; k < 8; k++) exp_line[k*64 +: 64] = dv(7, (k + 5) % 8);
    check("t6.wren", 512'(bus.wren_o), 512'd1);
    check("t6.waddr", 512'(bus.waddr_o), 512'h103);
    check("t6.tag", 512'(bus.wdata_tag_o), 512'({1'b1, 17'h0}));
    check("t6.data", 512'(bus.wdata_data_o), exp_line);
    check("t6.crit_data", 512'(bus.crit_data_o), 512'(dv(7, 0)));
    check("t6.crit_pulses", 512'(crit_cnt), 512'd1);
    bus.wready_i = 1'b1;
    tick();
    bus.wready_i = 1'b0;

    // ---- BEATS=2 build: offset 1, index 1, tag 0 ----
    bus2.miss_addr_fifo_rdata_i = 32'h0000_0030;
    bus2.miss_addr_fifo_empty_i = 1'b0;
    tick();
    bus2.miss_addr_fifo_empty_i = 1'b1;
    bus2.mem_rvalid_i = 1'b1;
    bus2.mem_rdata_i  = 128'hE0E0_0000_0000_0000_0000_0000_0000_00E0;
    bus2.mem_rlast_i  = 1'b0;
    tick();
    check("w2.crit_valid", 512'(bus2.crit_valid_o), 512'd1);
    bus2.mem_rdata_i  = 128'hE1E1_0000_0000_0000_0000_0000_0000_00E1;
    bus2.mem_rlast_i  = 1'b1;
    tick();
    bus2.mem_rvalid_i = 1'b0;
    bus2.mem_rlast_i  = 1'b0;
    check("w2.wren", 512'(bus2.wren_o), 512'd1);
    check("w2.waddr", 512'(bus2.waddr_o), 512'd1);
    check("w2.tag", 512'(bus2.wdata_tag_o), 512'({1'b1, 18'h0}));
    check("w2.data", 512'(bus2.wdata_data_o),
          512'({128'hE0E0_0000_0000_0000_0000_0000_0000_00E0,
                128'hE1E1_0000_0000_0000_0000_0000_0000_00E1}));
    bus2.wready_i = 1'b1;
    tick();
    bus2.wready_i = 1'b0;
    check("w2.busy_done", 512'(bus2.busy_o), 512'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
